ddr_a2m_beatgen: RTL and testbench

- Inverse of the bridge's total-size calculation. Takes a byte total plus an AXSIZE code and regenerates the AXI beat sequence.
- Outputs per beat: index, byte address and LAST; also reconstructs AXLEN.
- Sits on the MBA-to-AXI return side and paces R-channel (or W-accept) beats for one burst at a time.

---
 rtl/ddr_a2m_beatgen_pkg.sv | 28 ++
 rtl/ddr_a2m_beat_addr.sv | 30 +++
 rtl/ddr_a2m_beatgen.sv | 140 ++++++++++++++
 tb/tb_ddr_a2m_beatgen.sv | 198 +++++++++++++++++++
 4 files changed

// File: rtl/ddr_a2m_beatgen_pkg.sv
// Shared AXI codes, FSM states and helpers for the MBA-to-AXI beat generator.
// The WRAP helper is used only when DDR_A2M_BEATGEN_WRAP_EN is defined.
package ddr_a2m_beatgen_pkg;

  localparam logic [2:0] P_ASIZE_1  = 3'd0;
  localparam logic [2:0] P_ASIZE_2  = 3'd1;
  localparam logic [2:0] P_ASIZE_4  = 3'd2;
  localparam logic [2:0] P_ASIZE_8  = 3'd3;
  localparam logic [2:0] P_ASIZE_16 = 3'd4;

  localparam logic [1:0] P_ABURST_FIXED = 2'd0;
  localparam logic [1:0] P_ABURST_INCR  = 2'd1;
  localparam logic [1:0] P_ABURST_WRAP  = 2'd2;

  localparam int P_WINDOW   = 4096;
  localparam int P_MAXBEATS = 256;

  typedef enum logic {
    S_IDLE  = 1'b0,
    S_BURST = 1'b1
  } state_t;

  // AXI only allows WRAP bursts of 2, 4, 8 or 16 beats
  function automatic logic wrap_beats_ok(input logic [12:0] beats);
    return (beats == 13'd2) || (beats == 13'd4) || (beats == 13'd8) || (beats == 13'd16);
  endfunction

endpackage

// File: rtl/ddr_a2m_beat_addr.sv
// Combinational next-beat address for INCR and WRAP bursts.
// WRAP keeps the address inside the total-size aligned window.
module ddr_a2m_beat_addr
  import ddr_a2m_beatgen_pkg::*;
#(
  parameter int P_AW = 13
) (
  input  logic [P_AW-1:0] addr,
  input  logic [2:0]      size,
  input  logic [12:0]     total,
  input  logic [1:0]      burst,
  output logic [P_AW-1:0] next_addr
);

  logic [P_AW-1:0] step;
  logic [P_AW-1:0] incr;
  logic [P_AW-1:0] wmask;

  always_comb begin
    step  = P_AW'(1) << size;
    incr  = addr + step;
    wmask = P_AW'(total) - P_AW'(1);
    if (burst == P_ABURST_WRAP) begin
      next_addr = (addr & ~wmask) | (incr & wmask);
    end else begin
      next_addr = incr;
    end
  end

endmodule

// File: rtl/ddr_a2m_beatgen.sv
// Regenerates the AXI beat sequence (index, address, LAST, AXLEN) from a byte total
// and AXSIZE. Define DDR_A2M_BEATGEN_WRAP_EN to add CMD_BURST and WRAP addressing.
module ddr_a2m_beatgen
  import ddr_a2m_beatgen_pkg::*;
#(
  parameter int P_AW    = 13,
  parameter int P_MAXSZ = 4
) (
  input  logic            ACLK,
  input  logic            ARST,
  input  logic            CMD_VALID,
  output logic            CMD_READY,
  input  logic [12:0]     CMD_TOTAL,
  input  logic [2:0]      CMD_SIZE,
  input  logic [P_AW-1:0] CMD_ADDR,
`ifdef DDR_A2M_BEATGEN_WRAP_EN
  input  logic [1:0]      CMD_BURST,
`endif
  output logic            BEAT_VALID,
  input  logic            BEAT_READY,
  output logic            BEAT_LAST,
  output logic [7:0]      BEAT_IDX,
  output logic [P_AW-1:0] BEAT_ADDR,
  output logic [7:0]      BEAT_LEN,
  output logic            CMD_ERR
);

  state_t          state_reg;
  logic            cmd_ready_reg;
  logic            beat_valid_reg;
  logic            cmd_err_reg;
  logic [7:0]      idx_reg;
  logic [7:0]      len_reg;
  logic [P_AW-1:0] addr_reg;
  logic [2:0]      size_reg;
  logic [12:0]     total_reg;
  logic [1:0]      burst_reg;

  logic [1:0]      burst_in;
  logic [12:0]     beats;
  logic [12:0]     low_mask;
  logic [P_AW-1:0] start_addr;
  logic            cmd_legal;
  logic [P_AW-1:0] addr_next;
  logic            beat_last;

  always_comb begin
`ifdef DDR_A2M_BEATGEN_WRAP_EN
    burst_in = CMD_BURST;
`else
    burst_in = P_ABURST_INCR;
`endif
    beats      = CMD_TOTAL >> CMD_SIZE;
    low_mask   = (13'd1 << CMD_SIZE) - 13'd1;
    start_addr = CMD_ADDR & ~((P_AW'(1) << CMD_SIZE) - P_AW'(1));
    cmd_legal  = (int'(CMD_SIZE) <= P_MAXSZ) && (CMD_TOTAL != 13'd0) &&
                 ((CMD_TOTAL & low_mask) == 13'd0) &&
                 (beats >= 13'd1) && (int'(beats) <= P_MAXBEATS);
`ifdef DDR_A2M_BEATGEN_WRAP_EN
    if (burst_in == P_ABURST_WRAP) begin
      cmd_legal = cmd_legal && wrap_beats_ok(beats);
    end else if (burst_in != P_ABURST_INCR) begin
      cmd_legal = 1'b0;
    end
`endif
  end

  ddr_a2m_beat_addr #(.P_AW(P_AW)) u_beat_addr (
    .addr      (addr_reg),
    .size      (size_reg),
    .total     (total_reg),
    .burst     (burst_reg),
    .next_addr (addr_next)
  );

  // Gated by VALID so the idle/reset state (IDX==LEN==0) never shows LAST
  assign beat_last = beat_valid_reg && (idx_reg == len_reg);

  always_ff @(posedge ACLK) begin
    if (ARST) begin
      state_reg      <= S_IDLE;
      cmd_ready_reg  <= 1'b1;
      beat_valid_reg <= 1'b0;
      cmd_err_reg    <= 1'b0;
      idx_reg        <= '0;
      len_reg        <= '0;
      addr_reg       <= '0;
      size_reg       <= '0;
      total_reg      <= '0;
      burst_reg      <= P_ABURST_INCR;
    end else begin
      cmd_err_reg <= 1'b0;
      case (state_reg)
        S_IDLE: begin
          if (CMD_VALID && cmd_ready_reg) begin
            if (cmd_legal) begin
              state_reg      <= S_BURST;
              cmd_ready_reg  <= 1'b0;
              beat_valid_reg <= 1'b1;
              idx_reg        <= '0;
              len_reg        <= 8'(beats - 13'd1);
              addr_reg       <= start_addr;
              size_reg       <= CMD_SIZE;
              total_reg      <= CMD_TOTAL;
              burst_reg      <= burst_in;
            end else begin
              cmd_err_reg <= 1'b1;
            end
          end
        end
        S_BURST: begin
          if (BEAT_READY) begin
            if (beat_last) begin
              state_reg      <= S_IDLE;
              cmd_ready_reg  <= 1'b1;
              beat_valid_reg <= 1'b0;
            end else begin
              idx_reg  <= idx_reg + 8'd1;
              addr_reg <= addr_next;
            end
          end
        end
        default: begin
          state_reg      <= S_IDLE;
          cmd_ready_reg  <= 1'b1;
          beat_valid_reg <= 1'b0;
        end
      endcase
    end
  end

  assign CMD_READY  = cmd_ready_reg;
  assign BEAT_VALID = beat_valid_reg;
  assign BEAT_LAST  = beat_last;
  assign BEAT_IDX   = idx_reg;
  assign BEAT_ADDR  = addr_reg;
  assign BEAT_LEN   = len_reg;
  assign CMD_ERR    = cmd_err_reg;

endmodule

// File: tb/tb_ddr_a2m_beatgen.sv
// Directed bench for ddr_a2m_beatgen; WRAP cases run when DDR_A2M_BEATGEN_WRAP_EN is defined.
module tb_ddr_a2m_beatgen;
  import ddr_a2m_beatgen_pkg::*;

  logic        ACLK = 1'b0;
  logic        ARST = 1'b1;
  logic        CMD_VALID = 1'b0;
  logic        CMD_READY;
  logic [12:0] CMD_TOTAL = '0;
  logic [2:0]  CMD_SIZE = '0;
  logic [12:0] CMD_ADDR = '0;
`ifdef DDR_A2M_BEATGEN_WRAP_EN
  logic [1:0]  CMD_BURST = P_ABURST_INCR;
`endif
  logic        BEAT_VALID;
  logic        BEAT_READY = 1'b0;
  logic        BEAT_LAST;
  logic [7:0]  BEAT_IDX;
  logic [12:0] BEAT_ADDR;
  logic [7:0]  BEAT_LEN;
  logic        CMD_ERR;

  int checks = 0;
  int failures = 0;

  ddr_a2m_beatgen #(.P_AW(13), .P_MAXSZ(4)) dut (
    .ACLK       (ACLK),
    .ARST       (ARST),
    .CMD_VALID  (CMD_VALID),
    .CMD_READY  (CMD_READY),
    .CMD_TOTAL  (CMD_TOTAL),
    .CMD_SIZE   (CMD_SIZE),
    .CMD_ADDR   (CMD_ADDR),
`ifdef DDR_A2M_BEATGEN_WRAP_EN
    .CMD_BURST  (CMD_BURST),
`endif
    .BEAT_VALID (BEAT_VALID),
    .BEAT_READY (BEAT_READY),
    .BEAT_LAST  (BEAT_LAST),
    .BEAT_IDX   (BEAT_IDX),
    .BEAT_ADDR  (BEAT_ADDR),
    .BEAT_LEN   (BEAT_LEN),
    .CMD_ERR    (CMD_ERR)
  );

  always #5 ACLK = ~ACLK;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge ACLK);
    #1;
  endtask

  task automatic send_cmd(input logic [12:0] total, input logic [2:0] size, input logic [12:0] addr);
    $display("cmd total=%0d size=%0d addr=0x%0h", total, size, addr);
    CMD_VALID = 1'b1;
    CMD_TOTAL = total;
    CMD_SIZE  = size;
    CMD_ADDR  = addr;
    tick();
    CMD_VALID = 1'b0;
  endtask

  // READY held high; expected address is a0 + i*step for INCR bursts
  task automatic run_incr(input string tag, input int nbeats, input logic [12:0] a0,
                          input logic [12:0] step, input logic [7:0] len);
    logic [12:0] exp_addr;
    BEAT_READY = 1'b1;
    chk({tag, "_cmd_ready_busy"}, 32'(CMD_READY), 32'd0);
    for (int i = 0; i < nbeats; i++) begin
      exp_addr = a0 + 13'(i) * step;
      chk({tag, "_valid"}, 32'(BEAT_VALID), 32'd1);
      chk({tag, "_idx"},   32'(BEAT_IDX), 32'(i));
      chk({tag, "_addr"},  32'(BEAT_ADDR), 32'(exp_addr));
      chk({tag, "_len"},   32'(BEAT_LEN), 32'(len));
      chk({tag, "_last"},  32'(BEAT_LAST), (i == nbeats - 1) ? 32'd1 : 32'd0);
      tick();
    end
    chk({tag, "_valid_end"}, 32'(BEAT_VALID), 32'd0);
    chk({tag, "_ready_end"}, 32'(CMD_READY), 32'd1);
    chk({tag, "_last_end"},  32'(BEAT_LAST), 32'd0);
  endtask

  task automatic expect_err(input string tag);
    chk({tag, "_err"},   32'(CMD_ERR), 32'd1);
    chk({tag, "_valid"}, 32'(BEAT_VALID), 32'd0);
    chk({tag, "_ready"}, 32'(CMD_READY), 32'd1);
    tick();
    chk({tag, "_err_pulse"}, 32'(CMD_ERR), 32'd0);
    chk({tag, "_valid2"},    32'(BEAT_VALID), 32'd0);
  endtask

  initial begin
    logic        rdy_seq [5] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
    logic [7:0]  idx_seq [5] = '{8'd0, 8'd0, 8'd1, 8'd1, 8'd1};
    logic [12:0] adr_seq [5] = '{13'h040, 13'h040, 13'h044, 13'h044, 13'h044};

    tick();
    tick();
    ARST = 1'b0;
    chk("rst_cmd_ready", 32'(CMD_READY), 32'd1);
    chk("rst_valid",     32'(BEAT_VALID), 32'd0);
    chk("rst_last",      32'(BEAT_LAST), 32'd0);
    chk("rst_idx",       32'(BEAT_IDX), 32'd0);
    chk("rst_addr",      32'(BEAT_ADDR), 32'd0);
    chk("rst_len",       32'(BEAT_LEN), 32'd0);
    chk("rst_err",       32'(CMD_ERR), 32'd0);

    // 64 bytes of 16-byte beats: 0x100,0x110,0x120,0x130
    send_cmd(13'd64, P_ASIZE_16, 13'h100);
    run_incr("b64", 4, 13'h100, 13'h010, 8'd3);

    // unaligned start is aligned down to the beat size
    send_cmd(13'd32, P_ASIZE_8, 13'h10B);
    run_incr("b32u", 4, 13'h108, 13'h008, 8'd3);

    // full 4 KB: 256 beats, last address = start + 0xFF0 (carry into bit 12)
    send_cmd(13'd4096, P_ASIZE_16, 13'h010);
    run_incr("b4k", 256, 13'h010, 13'h010, 8'hFF);

    // single beat: LAST on the first beat
    send_cmd(13'd8, P_ASIZE_8, 13'h080);
    run_incr("b1", 1, 13'h080, 13'h008, 8'd0);

    // illegal commands are consumed with a single-cycle error pulse
    send_cmd(13'd6, P_ASIZE_4, 13'h000);
    expect_err("e_misalign");
    send_cmd(13'd0, P_ASIZE_1, 13'h000);
    expect_err("e_zero");
    send_cmd(13'd64, 3'd5, 13'h000);
    expect_err("e_size");
    send_cmd(13'd4096, P_ASIZE_1, 13'h000);
    expect_err("e_beats");

    // stalls: READY pattern 0,1,0,0,1 over a two-beat burst
    send_cmd(13'd8, P_ASIZE_4, 13'h040);
    for (int i = 0; i < 5; i++) begin
      BEAT_READY = rdy_seq[i];
      chk("stall_valid", 32'(BEAT_VALID), 32'd1);
      chk("stall_idx",   32'(BEAT_IDX), 32'(idx_seq[i]));
      chk("stall_addr",  32'(BEAT_ADDR), 32'(adr_seq[i]));
      chk("stall_len",   32'(BEAT_LEN), 32'd1);
      chk("stall_last",  32'(BEAT_LAST), (idx_seq[i] == 8'd1) ? 32'd1 : 32'd0);
      tick();
    end
    chk("stall_valid_end", 32'(BEAT_VALID), 32'd0);
    chk("stall_ready_end", 32'(CMD_READY), 32'd1);

    // reset after two of eight beats
    send_cmd(13'd64, P_ASIZE_8, 13'h200);
    BEAT_READY = 1'b1;
    tick();
    tick();
    chk("mid_idx_pre", 32'(BEAT_IDX), 32'd2);
    ARST = 1'b1;
    tick();
    ARST = 1'b0;
    chk("mid_valid", 32'(BEAT_VALID), 32'd0);
    chk("mid_idx",   32'(BEAT_IDX), 32'd0);
    chk("mid_addr",  32'(BEAT_ADDR), 32'd0);
    chk("mid_len",   32'(BEAT_LEN), 32'd0);
    chk("mid_ready", 32'(CMD_READY), 32'd1);
    chk("mid_last",  32'(BEAT_LAST), 32'd0);
    send_cmd(13'd64, P_ASIZE_16, 13'h300);
    run_incr("post_rst", 4, 13'h300, 13'h010, 8'd3);

`ifdef DDR_A2M_BEATGEN_WRAP_EN
    begin
      logic [12:0] wrap_exp [4] = '{13'h120, 13'h130, 13'h100, 13'h110};
      CMD_BURST = P_ABURST_WRAP;
      send_cmd(13'd64, P_ASIZE_16, 13'h128);
      BEAT_READY = 1'b1;
      for (int i = 0; i < 4; i++) begin
        chk("wrap_valid", 32'(BEAT_VALID), 32'd1);
        chk("wrap_idx",   32'(BEAT_IDX), 32'(i));
        chk("wrap_addr",  32'(BEAT_ADDR), 32'(wrap_exp[i]));
        chk("wrap_last",  32'(BEAT_LAST), (i == 3) ? 32'd1 : 32'd0);
        tick();
      end
      chk("wrap_valid_end", 32'(BEAT_VALID), 32'd0);
      send_cmd(13'd48, P_ASIZE_16, 13'h000);
      expect_err("wrap_e3");
      CMD_BURST = P_ABURST_INCR;
    end
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
